// File: rtl/id_ex_operand_stage.sv
// -----------------------------------------------------------------------------
// id_ex_operand_stage
//
// Pipeline register between decode and the ALU. It captures a decoded
// instruction, resolves operand forwarding from the execute and memory
// stages, and presents ALU operand A/B and opcode to execute. Both sides
// use a valid/ready handshake. While an instruction is held because execute
// is stalled, register-sourced operands keep watching the forwarding buses,
// so a result that arrives late still lands in the held operand.
//
// Ports
//   clk, rst            clock and synchronous active-high reset
//   in_valid/in_ready   decode-side handshake (in_ready is combinational)
//   in_rs1/rs2_addr     source register indices
//   in_rs1/rs2_data     register file read data
//   in_imm, in_pc       immediate and PC operand candidates
//   in_use_pc/use_imm   operand A from PC / operand B from immediate
//   in_rd_addr          destination register, carried forward
//   in_alu_op           ALU opcode, carried forward
//   ex_fwd_*            execute-stage result forwarding bus
//   mem_fwd_*           memory-stage result forwarding bus
//   flush               kills the held and the incoming instruction
//   out_valid/out_ready execute-side handshake
//   ain, bin, alu_op    ALU operands and opcode (registered)
//   out_rd_addr         destination register (registered)
// -----------------------------------------------------------------------------
module id_ex_operand_stage #(
    parameter int XLEN = 32,
    parameter int OPW  = 5,
    parameter int RAW  = 5
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            in_valid,
    output logic            in_ready,
    input  logic [RAW-1:0]  in_rs1_addr,
    input  logic [RAW-1:0]  in_rs2_addr,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [XLEN-1:0] in_imm,
    input  logic [XLEN-1:0] in_pc,
    input  logic            in_use_pc,
    input  logic            in_use_imm,
    input  logic [RAW-1:0]  in_rd_addr,
    input  logic [OPW-1:0]  in_alu_op,

    input  logic            ex_fwd_valid,
    input  logic [RAW-1:0]  ex_fwd_rd,
    input  logic [XLEN-1:0] ex_fwd_data,
    input  logic            mem_fwd_valid,
    input  logic [RAW-1:0]  mem_fwd_rd,
    input  logic [XLEN-1:0] mem_fwd_data,

    input  logic            flush,

    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] ain,
    output logic [XLEN-1:0] bin,
    output logic [OPW-1:0]  alu_op,
    output logic [RAW-1:0]  out_rd_addr
);

    localparam logic [RAW-1:0] REG_ZERO = {RAW{1'b0}};

    // Pick the freshest value for a source register. Execute wins over
    // memory because it holds the younger result; x0 is never forwarded.
    function automatic logic [XLEN-1:0] pick_src(
        input logic [RAW-1:0]  addr,
        input logic [XLEN-1:0] fallback,
        input logic            exv,
        input logic [RAW-1:0]  exrd,
        input logic [XLEN-1:0] exd,
        input logic            memv,
        input logic [RAW-1:0]  memrd,
        input logic [XLEN-1:0] memd
    );
        logic [XLEN-1:0] r;
        if (exv && (exrd == addr) && (addr != REG_ZERO)) begin
            r = exd;
        end else if (memv && (memrd == addr) && (addr != REG_ZERO)) begin
            r = memd;
        end else begin
            r = fallback;
        end
        return r;
    endfunction

    logic            valid_q,  valid_d;
    logic [XLEN-1:0] ain_q,    ain_d;
    logic [XLEN-1:0] bin_q,    bin_d;
    logic [OPW-1:0]  op_q,     op_d;
    logic [RAW-1:0]  rd_q,     rd_d;
    // Source tags: register index behind each operand, and whether the
    // operand tracks a register at all (cleared for PC/imm and for x0).
    logic [RAW-1:0]  a_tag_q,  a_tag_d;
    logic [RAW-1:0]  b_tag_q,  b_tag_d;
    logic            a_live_q, a_live_d;
    logic            b_live_q, b_live_d;

    logic accept_s;
    logic xfer_s;
    logic held_s;

    assign in_ready = !valid_q || out_ready;
    assign accept_s = in_valid && in_ready && !flush;
    assign xfer_s   = valid_q && out_ready;
    // Snooping only while truly held, so it never fires on a transfer cycle.
    assign held_s   = valid_q && !out_ready;

    // Next-state selection: accept, snoop while held, or hold.
    always_comb begin
        valid_d  = valid_q;
        ain_d    = ain_q;
        bin_d    = bin_q;
        op_d     = op_q;
        rd_d     = rd_q;
        a_tag_d  = a_tag_q;
        b_tag_d  = b_tag_q;
        a_live_d = a_live_q;
        b_live_d = b_live_q;

        if (flush) begin
            valid_d = 1'b0;
        end else if (accept_s) begin
            valid_d = 1'b1;
        end else if (xfer_s) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        if (accept_s) begin
            op_d     = in_alu_op;
            rd_d     = in_rd_addr;
            a_tag_d  = in_rs1_addr;
            b_tag_d  = in_rs2_addr;
            a_live_d = !in_use_pc  && (in_rs1_addr != REG_ZERO);
            b_live_d = !in_use_imm && (in_rs2_addr != REG_ZERO);
            if (in_use_pc) begin
                ain_d = in_pc;
            end else begin
                ain_d = pick_src(in_rs1_addr, in_rs1_data,
                                 ex_fwd_valid, ex_fwd_rd, ex_fwd_data,
                                 mem_fwd_valid, mem_fwd_rd, mem_fwd_data);
            end
            if (in_use_imm) begin
                bin_d = in_imm;
            end else begin
                bin_d = pick_src(in_rs2_addr, in_rs2_data,
                                 ex_fwd_valid, ex_fwd_rd, ex_fwd_data,
                                 mem_fwd_valid, mem_fwd_rd, mem_fwd_data);
            end
        end else if (held_s) begin
            if (a_live_q) begin
                ain_d = pick_src(a_tag_q, ain_q,
                                 ex_fwd_valid, ex_fwd_rd, ex_fwd_data,
                                 mem_fwd_valid, mem_fwd_rd, mem_fwd_data);
            end else begin
                ain_d = ain_q;
            end
            if (b_live_q) begin
                bin_d = pick_src(b_tag_q, bin_q,
                                 ex_fwd_valid, ex_fwd_rd, ex_fwd_data,
                                 mem_fwd_valid, mem_fwd_rd, mem_fwd_data);
            end else begin
                bin_d = bin_q;
            end
        end else begin
            ain_d = ain_q;
            bin_d = bin_q;
        end
    end

    // State register with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            ain_q    <= {XLEN{1'b0}};
            bin_q    <= {XLEN{1'b0}};
            op_q     <= {OPW{1'b0}};
            rd_q     <= {RAW{1'b0}};
            a_tag_q  <= {RAW{1'b0}};
            b_tag_q  <= {RAW{1'b0}};
            a_live_q <= 1'b0;
            b_live_q <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            ain_q    <= ain_d;
            bin_q    <= bin_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            a_tag_q  <= a_tag_d;
            b_tag_q  <= b_tag_d;
            a_live_q <= a_live_d;
            b_live_q <= b_live_d;
        end
    end

    assign out_valid   = valid_q;
    assign ain         = ain_q;
    assign bin         = bin_q;
    assign alu_op      = op_q;
    assign out_rd_addr = rd_q;

endmodule
